// File: rtl/pwm_regs_mc_if.sv
`timescale 1ns/1ps
// Byte-wide decoder bus into the multi-channel PWM register bank.
// read/write are single-cycle strobes with no ready: a write lands on the edge it is high, data_read is valid combinationally while read is high.
interface pwm_regs_mc_if #(
   parameter int AW = 8
);
   logic          read;
   logic          write;
   logic [AW-1:0] addr;
   logic [7:0]    data_write;
   logic [7:0]    data_read;

   modport master (output read, write, addr, data_write, input data_read);
   modport slave  (input read, write, addr, data_write, output data_read);
endinterface

// File: rtl/pwm_regs_mc.sv
`timescale 1ns/1ps
// Register bank for an NCH-channel PWM timer: staged/active compare, period and channel control,
// coherent counter snapshot and masked W1C compare-match interrupts.
module pwm_regs_mc #(
   parameter int NCH = 4,
   parameter int CW  = 16,
   parameter int AW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   pwm_regs_mc_if.slave      bus,
   input  logic [CW-1:0]     counter_val,
   input  logic              update_evt,
   input  logic [NCH-1:0]    cmp_match,
   output logic [CW-1:0]     period,
   output logic              en,
   output logic              upnotdown,
   output logic              count_reset,
   output logic [7:0]        prescale,
   output logic [NCH-1:0]    pwm_en,
   output logic [2*NCH-1:0]  functions,
   output logic [NCH*CW-1:0] compare1,
   output logic [NCH*CW-1:0] compare2,
   output logic              irq
);
   localparam int NB = CW / 8;

   logic [CW-1:0]          period_stg, period_nxt, period_act;
   logic [NCH-1:0]         pen_stg, pen_nxt, pen_act;
   logic [NCH-1:0][1:0]    fn_stg, fn_nxt, fn_act;
   logic [NCH-1:0][CW-1:0] cmp1_stg, cmp1_nxt, cmp1_act;
   logic [NCH-1:0][CW-1:0] cmp2_stg, cmp2_nxt, cmp2_act;
   logic                   shadow_en;
   logic                   force_pend;
   logic [CW-1:0]          snap;
   logic [NCH-1:0]         status, mask, status_clr;
   logic                   wr_ctrl;
   int                     ad, ch, off;

   function automatic logic [7:0] get_byte(input logic [CW-1:0] v, input int k);
      get_byte = 8'h00;
      for (int i = 0; i < NB; i++)
         if (i == k) get_byte = v[8*i +: 8];
   endfunction

   function automatic logic [CW-1:0] put_byte(input logic [CW-1:0] v, input int k,
                                              input logic [7:0] b);
      put_byte = v;
      for (int i = 0; i < NB; i++)
         if (i == k) put_byte[8*i +: 8] = b;
   endfunction

   always_comb begin
      ad  = int'(bus.addr);
      ch  = ad / 16 - 1;
      off = ad % 16;
   end

   assign wr_ctrl    = bus.write && (ad == 0);
   assign status_clr = (bus.write && ad == 12) ? bus.data_write[NCH-1:0] : '0;

   // Staging values after this cycle's write; the active copies pick these up when unshadowed.
   always_comb begin
      period_nxt = period_stg;
      pen_nxt    = pen_stg;
      fn_nxt     = fn_stg;
      cmp1_nxt   = cmp1_stg;
      cmp2_nxt   = cmp2_stg;
      if (bus.write) begin
         if (ad >= 4 && ad < 8) period_nxt = put_byte(period_stg, ad - 4, bus.data_write);
         for (int n = 0; n < NCH; n++) begin
            if (ad >= 16 && ch == n) begin
               if (off == 0) begin
                  pen_nxt[n] = bus.data_write[0];
                  fn_nxt[n]  = bus.data_write[2:1];
               end
               if (off >= 4 && off < 8)
                  cmp1_nxt[n] = put_byte(cmp1_stg[n], off - 4, bus.data_write);
               if (off >= 8 && off < 12)
                  cmp2_nxt[n] = put_byte(cmp2_stg[n], off - 8, bus.data_write);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_stg <= '0;
         pen_stg    <= '0;
         fn_stg     <= '0;
         cmp1_stg   <= '0;
         cmp2_stg   <= '0;
      end else begin
         period_stg <= period_nxt;
         pen_stg    <= pen_nxt;
         fn_stg     <= fn_nxt;
         cmp1_stg   <= cmp1_nxt;
         cmp2_stg   <= cmp2_nxt;
      end
   end

   // A commit takes the pre-write staging value; a byte written on the commit edge waits for the next event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_act <= '0;
         pen_act    <= '0;
         fn_act     <= '0;
         cmp1_act   <= '0;
         cmp2_act   <= '0;
      end else if (!shadow_en) begin
         period_act <= period_nxt;
         pen_act    <= pen_nxt;
         fn_act     <= fn_nxt;
         cmp1_act   <= cmp1_nxt;
         cmp2_act   <= cmp2_nxt;
      end else if (update_evt || force_pend) begin
         period_act <= period_stg;
         pen_act    <= pen_stg;
         fn_act     <= fn_stg;
         cmp1_act   <= cmp1_stg;
         cmp2_act   <= cmp2_stg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en          <= 1'b0;
         upnotdown   <= 1'b0;
         shadow_en   <= 1'b0;
         count_reset <= 1'b0;
         force_pend  <= 1'b0;
         prescale    <= 8'h00;
         mask        <= '0;
         status      <= '0;
         snap        <= '0;
      end else begin
         count_reset <= wr_ctrl && bus.data_write[2];
         force_pend  <= wr_ctrl && bus.data_write[4];
         if (wr_ctrl) begin
            en        <= bus.data_write[0];
            upnotdown <= bus.data_write[1];
            shadow_en <= bus.data_write[3];
         end
         if (bus.write && ad == 1)  prescale <= bus.data_write;
         if (bus.write && ad == 13) mask     <= bus.data_write[NCH-1:0];
         // Set beats clear when both land on the same bit.
         status <= (status & ~status_clr) | cmp_match;
         if (bus.read && ad == 8) snap <= counter_val;
      end
   end

   always_comb begin
      bus.data_read = 8'h00;
      if (bus.read) begin
         if (ad == 0)                bus.data_read = {4'b0, shadow_en, 1'b0, upnotdown, en};
         else if (ad == 1)           bus.data_read = prescale;
         else if (ad >= 4 && ad < 8) bus.data_read = get_byte(period_stg, ad - 4);
         else if (ad == 8)           bus.data_read = counter_val[7:0];
         else if (ad > 8 && ad < 12) bus.data_read = get_byte(snap, ad - 8);
         else if (ad == 12)          bus.data_read = 8'(status);
         else if (ad == 13)          bus.data_read = 8'(mask);
         else if (ad >= 16) begin
            for (int n = 0; n < NCH; n++) begin
               if (ch == n) begin
                  if (off == 0)                 bus.data_read = {5'b0, fn_stg[n], pen_stg[n]};
                  else if (off >= 4 && off < 8) bus.data_read = get_byte(cmp1_stg[n], off - 4);
                  else if (off >= 8 && off < 12) bus.data_read = get_byte(cmp2_stg[n], off - 8);
               end
            end
         end
      end
   end

   assign period    = period_act;
   assign pwm_en    = pen_act;
   assign functions = fn_act;
   assign compare1  = cmp1_act;
   assign compare2  = cmp2_act;
   assign irq       = |(status & mask);
endmodule

// File: tb/tb_pwm_regs_mc.sv
`timescale 1ns/1ps
// Directed bench for pwm_regs_mc (NCH=4, CW=16): register access, shadow commit,
// strobes, counter snapshot, interrupts and asynchronous reset.
module tb_pwm_regs_mc;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int AW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CW-1:0]     counter_val = '0;
  logic              update_evt = 1'b0;
  logic [NCH-1:0]    cmp_match = '0;
  logic [CW-1:0]     period;
  logic              en, upnotdown, count_reset, irq;
  logic [7:0]        prescale;
  logic [NCH-1:0]    pwm_en;
  logic [2*NCH-1:0]  functions;
  logic [NCH*CW-1:0] compare1, compare2;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd;

  pwm_regs_mc_if #(.AW(AW)) bus ();

  pwm_regs_mc #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .counter_val(counter_val), .update_evt(update_evt), .cmp_match(cmp_match),
    .period(period), .en(en), .upnotdown(upnotdown), .count_reset(count_reset),
    .prescale(prescale), .pwm_en(pwm_en), .functions(functions),
    .compare1(compare1), .compare2(compare2), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.write = 1'b1; bus.addr = a; bus.data_write = d;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.read = 1'b1; bus.addr = a;
    #1 d = bus.data_read;
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  task automatic pulse_update();
    @(negedge clk); update_evt = 1'b1;
    @(posedge clk); #1; update_evt = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 64'(period), 64'h0);
    check({tag, "_ctl"}, 64'({en, upnotdown, count_reset, irq}), 64'h0);
    check({tag, "_prescale"}, 64'(prescale), 64'h0);
    check({tag, "_chan"}, 64'({pwm_en, functions}), 64'h0);
    check({tag, "_cmp1"}, compare1, 64'h0);
    check({tag, "_cmp2"}, compare2, 64'h0);
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.data_write = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // unshadowed compare1 ch0
    bus_write(8'h14, 8'h34);
    check("cmp1_lo_only", 64'(compare1[15:0]), 64'h0034);
    bus_write(8'h15, 8'h12);
    check("cmp1_unshadowed", 64'(compare1[15:0]), 64'h1234);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'h00);
    bus_read(8'h14, rd); check("rd_cmp1_b0", 64'(rd), 64'(exp_q.pop_front()));
    bus_read(8'h15, rd); check("rd_cmp1_b1", 64'(rd), 64'(exp_q.pop_front()));
    bus_read(8'h16, rd); check("rd_cmp1_b2", 64'(rd), 64'(exp_q.pop_front()));

    // period, prescale, direct control
    bus_write(8'h04, 8'hFF);
    bus_write(8'h05, 8'h01);
    check("period", 64'(period), 64'h01FF);
    bus_write(8'h01, 8'h07);
    check("prescale", 64'(prescale), 64'h07);
    bus_write(8'h00, 8'h03);
    check("en_dir", 64'({en, upnotdown}), 64'h3);
    bus_read(8'h00, rd); check("rd_ctrl", 64'(rd), 64'h03);

    // channel control ch3, out-of-range channel, unmapped
    bus_write(8'h40, 8'h05);
    check("pwm_en", 64'(pwm_en), 64'h8);
    check("functions", 64'(functions), 64'h80);
    bus_write(8'h50, 8'hFF);
    check("ch4_ignored", 64'({pwm_en, functions}), 64'h880);
    bus_read(8'h50, rd); check("rd_ch4", 64'(rd), 64'h00);
    bus_read(8'h02, rd); check("rd_unmapped", 64'(rd), 64'h00);
    bus_read(8'h40, rd); check("rd_chctrl3", 64'(rd), 64'h05);

    // shadowed commit on update_evt
    bus_write(8'h00, 8'h0B);
    bus_write(8'h14, 8'h56);
    bus_write(8'h28, 8'hF0);
    bus_write(8'h29, 8'h00);
    check("cmp1_held", 64'(compare1[15:0]), 64'h1234);
    check("cmp2_held", 64'(compare2[31:16]), 64'h0000);
    bus_read(8'h28, rd); check("rd_cmp2_stg", 64'(rd), 64'hF0);
    bus_read(8'h14, rd); check("rd_cmp1_stg", 64'(rd), 64'h56);
    pulse_update();
    check("cmp2_commit", 64'(compare2[31:16]), 64'h00F0);
    check("cmp1_commit", 64'(compare1[15:0]), 64'h1256);

    // force_load without update_evt
    bus_write(8'h28, 8'h0F);
    check("cmp2_held2", 64'(compare2[31:16]), 64'h00F0);
    bus_write(8'h00, 8'h1B);
    check("force_write_edge", 64'(compare2[31:16]), 64'h00F0);
    @(posedge clk); #1;
    check("force_commit", 64'(compare2[31:16]), 64'h000F);
    bus_read(8'h00, rd); check("rd_ctrl_force", 64'(rd), 64'h0B);

    // write and commit on the same edge
    bus_write(8'h29, 8'h11);
    @(negedge clk);
    bus.write = 1'b1; bus.addr = 8'h28; bus.data_write = 8'hAA; update_evt = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0; update_evt = 1'b0;
    check("same_cycle_commit", 64'(compare2[31:16]), 64'h110F);
    pulse_update();
    check("next_commit", 64'(compare2[31:16]), 64'h11AA);

    // count_reset back-to-back
    check("cnt_rst_idle", 64'(count_reset), 64'h0);
    bus_write(8'h00, 8'h0F);
    check("cnt_rst_1", 64'(count_reset), 64'h1);
    bus_write(8'h00, 8'h0F);
    check("cnt_rst_2", 64'(count_reset), 64'h1);
    @(posedge clk); #1;
    check("cnt_rst_end", 64'(count_reset), 64'h0);
    bus_read(8'h00, rd); check("rd_ctrl_cr", 64'(rd), 64'h0B);

    // counter snapshot
    counter_val = 16'hAB12;
    bus_read(8'h08, rd); check("snap_b0", 64'(rd), 64'h12);
    counter_val = 16'hCD34;
    bus_read(8'h09, rd); check("snap_b1", 64'(rd), 64'hAB);
    bus_read(8'h08, rd); check("snap_b0_2", 64'(rd), 64'h34);
    bus_read(8'h09, rd); check("snap_b1_2", 64'(rd), 64'hCD);

    // interrupts
    bus_write(8'h0D, 8'h02);
    @(negedge clk); cmp_match = 4'b0011;
    @(posedge clk); #1; cmp_match = 4'b0000;
    bus_read(8'h0C, rd); check("irq_status", 64'(rd), 64'h03);
    check("irq_on", 64'(irq), 64'h1);
    @(negedge clk);
    bus.write = 1'b1; bus.addr = 8'h0C; bus.data_write = 8'h02; cmp_match = 4'b0010;
    @(posedge clk); #1;
    bus.write = 1'b0; cmp_match = 4'b0000;
    bus_read(8'h0C, rd); check("set_wins", 64'(rd), 64'h03);
    bus_write(8'h0C, 8'h02);
    bus_read(8'h0C, rd); check("w1c", 64'(rd), 64'h01);
    check("irq_off", 64'(irq), 64'h0);
    bus_read(8'h0D, rd); check("rd_mask", 64'(rd), 64'h02);

    // asynchronous reset mid-operation with staged data
    bus_write(8'h0D, 8'h01);
    bus_write(8'h04, 8'h55);
    check("irq_pre_reset", 64'(irq), 64'h1);
    check("period_held", 64'(period), 64'h01FF);
    counter_val = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int a = 0; a < 8'h50; a++) begin
      bus_read(8'(a), rd);
      check($sformatf("rd_after_reset_%0h", a), 64'(rd), 64'h0);
    end
    check("irq_after_reset", 64'(irq), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
